uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 88 ++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1/8N2 UART transmitter with a runtime baud divisor
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 two_stop,
    input  logic                 wr,
    input  logic [7:0]           din,
    output logic                 full,
    output logic                 empty,
    output logic                 busy,
    output logic                 overflow,
    output logic                 UART_TX
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t               state, state_n;
    logic [7:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]        wptr, rptr;
    logic [CW-1:0]        count, count_n;
    logic [DIV_WIDTH-1:0] cnt, div_l;
    logic [7:0]           sh;
    logic [2:0]           bitn;
    logic                 two_l, stop2, tick, last_stop, pop, push, tx_n;
    always_comb begin
        tick      = cnt == '0;
        last_stop = state == STOP && tick && (!two_l || stop2);
        pop       = !empty && (state == IDLE || last_stop);
        push      = wr && (!full || pop);
        count_n   = count + CW'(push) - CW'(pop);
        state_n   = pop ? START :
                    (state == START && tick) ? DATA :
                    (state == DATA && tick && bitn == 3'd7) ? STOP :
                    last_stop ? IDLE : state;
        // the line is registered, so drive it from the bit the next state will present
        tx_n      = state_n == START ? 1'b0 :
                    state_n == DATA  ? ((state == DATA && tick) ? sh[1] : sh[0]) : 1'b1;
    end
    assign busy = state != IDLE;
    always_ff @(posedge clk_sys)
        if (push && !reset) mem[wptr] <= din;
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= IDLE;
            UART_TX  <= 1'b1;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            cnt      <= '0;
            div_l    <= '0;
            two_l    <= 1'b0;
            stop2    <= 1'b0;
            sh       <= '0;
            bitn     <= '0;
        end else begin
            state    <= state_n;
            UART_TX  <= tx_n;
            wptr     <= wptr + AW'(push);
            rptr     <= rptr + AW'(pop);
            count    <= count_n;
            full     <= count_n == CW'(FIFO_DEPTH);
            empty    <= count_n == '0;
            overflow <= overflow | (wr && full && !pop);
            if (pop) begin
                div_l <= baud_div;
                two_l <= two_stop;
                cnt   <= baud_div;
                sh    <= mem[rptr];
                bitn  <= '0;
                stop2 <= 1'b0;
            end else if (state != IDLE) begin
                cnt <= tick ? div_l : cnt - DIV_WIDTH'(1);
                if (tick && state == DATA) begin
                    sh   <= sh >> 1;
                    bitn <= bitn + 3'd1;
                end
                if (tick && state == STOP) stop2 <= 1'b1;
            end
        end
    end
endmodule
